// File: rtl/rob_commit_sequencer_pkg.sv
// Shared widths, register encodings and the reorder-buffer entry layout.
package rob_commit_sequencer_pkg;

  localparam int REG_WIDTH    = 5;
  localparam int EX_REG_WIDTH = 6;
  localparam logic [EX_REG_WIDTH-1:0] NON_REG = 6'b100000;

  typedef struct packed {
    logic                    valid;
    logic                    ready;
    logic                    is_branch;
    logic                    mispredict;
    logic [EX_REG_WIDTH-1:0] rd;
    logic [31:0]             value;
    logic [31:0]             target;
  } rob_entry_t;

  // x0 and "no destination" retire without touching the register file.
  function automatic logic writes_reg(input logic [EX_REG_WIDTH-1:0] rd);
    return (rd != NON_REG) && (rd[REG_WIDTH-1:0] != '0);
  endfunction

endpackage

// File: rtl/rob_commit_sequencer.sv
// Reorder buffer: in-order allocation, out-of-order writeback, one registered
// commit per cycle into the register file, full flush on a mispredicted branch.
module rob_commit_sequencer
  import rob_commit_sequencer_pkg::*;
#(
  parameter int RoB_WIDTH = 8
) (
  input  logic                    Sys_clk,
  input  logic                    Sys_rst,
  input  logic                    Sys_rdy,
  input  logic                    DPRoB_en,
  input  logic [EX_REG_WIDTH-1:0] DPRoB_rd,
  input  logic                    DPRoB_is_branch,
  output logic [RoB_WIDTH-1:0]    RoBDP_index,
  output logic                    RoBDP_full,
  input  logic                    CDBRoB_en,
  input  logic [RoB_WIDTH-1:0]    CDBRoB_index,
  input  logic [31:0]             CDBRoB_value,
  input  logic                    CDBRoB_mispredict,
  input  logic [31:0]             CDBRoB_target,
  output logic                    RoBRF_en,
  output logic [RoB_WIDTH-1:0]    RoBRF_RoB_index,
  output logic [REG_WIDTH-1:0]    RoBRF_rd,
  output logic [31:0]             RoBRF_value,
  output logic                    RoBRF_pre_judge,
  output logic                    RoBAll_flush,
  output logic [31:0]             RoBAll_flush_pc
);

  localparam int RoB_SIZE = 1 << RoB_WIDTH;
  localparam logic [RoB_WIDTH:0] COUNT_FULL = (RoB_WIDTH+1)'(RoB_SIZE);

  rob_entry_t           ent [RoB_SIZE];
  logic [RoB_WIDTH-1:0] head, tail;
  logic [RoB_WIDTH:0]   count;
  rob_entry_t           head_ent;
  logic                 alloc, wb, commit, misp;

  assign head_ent    = ent[head];
  assign RoBDP_index = tail;
  // A retire this cycle frees its slot only from the next cycle on.
  assign RoBDP_full  = (count == COUNT_FULL) || RoBAll_flush;
  assign alloc       = DPRoB_en && !RoBDP_full;
  assign wb          = CDBRoB_en && ent[CDBRoB_index].valid && !RoBAll_flush;
  assign commit      = (count != '0) && head_ent.ready;
  assign misp        = commit && head_ent.is_branch && head_ent.mispredict;

  always_ff @(posedge Sys_clk) begin
    if (Sys_rst) begin
      head            <= '0;
      tail            <= '0;
      count           <= '0;
      for (int i = 0; i < RoB_SIZE; i++) begin
        ent[i].valid <= 1'b0;
        ent[i].ready <= 1'b0;
      end
      RoBRF_en        <= 1'b0;
      RoBRF_RoB_index <= '0;
      RoBRF_rd        <= '0;
      RoBRF_value     <= '0;
      RoBRF_pre_judge <= 1'b1;
      RoBAll_flush    <= 1'b0;
      RoBAll_flush_pc <= '0;
    end else if (Sys_rdy) begin
      if (alloc) begin
        ent[tail].valid     <= 1'b1;
        ent[tail].ready     <= 1'b0;
        ent[tail].is_branch <= DPRoB_is_branch;
        ent[tail].rd        <= DPRoB_rd;
      end
      if (wb) begin
        ent[CDBRoB_index].ready      <= 1'b1;
        ent[CDBRoB_index].value      <= CDBRoB_value;
        ent[CDBRoB_index].mispredict <= CDBRoB_mispredict;
        ent[CDBRoB_index].target     <= CDBRoB_target;
      end
      if (commit) begin
        ent[head].valid <= 1'b0;
        ent[head].ready <= 1'b0;
      end

      // Mispredict discards every younger entry, including one allocated now.
      if (misp) begin
        for (int i = 0; i < RoB_SIZE; i++) begin
          ent[i].valid <= 1'b0;
          ent[i].ready <= 1'b0;
        end
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (commit) head <= head + 1'b1;
        if (alloc)  tail <= tail + 1'b1;
        case ({alloc, commit})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: ;
        endcase
      end

      RoBRF_en        <= commit && !misp && !head_ent.is_branch && writes_reg(head_ent.rd);
      RoBRF_pre_judge <= !misp;
      RoBAll_flush    <= misp;
      if (commit) begin
        RoBRF_RoB_index <= head;
        RoBRF_rd        <= head_ent.rd[REG_WIDTH-1:0];
        RoBRF_value     <= head_ent.value;
      end
      if (misp) RoBAll_flush_pc <= head_ent.target;
    end
  end

endmodule

// File: tb/tb_rob_commit_sequencer.sv
// Directed and randomized bench for rob_commit_sequencer (4-entry RoB),
// checked against a queue-based model of the in-flight entries.
module tb_rob_commit_sequencer;

  localparam int RW    = 2;
  localparam int DEPTH = 4;
  localparam logic [5:0] NREG = 6'b100000;

  logic          clk = 1'b0;
  logic          rst, rdy;
  logic          dp_en, dp_br;
  logic [5:0]    dp_rd;
  logic [RW-1:0] dp_idx;
  logic          dp_full;
  logic          cdb_en, cdb_misp;
  logic [RW-1:0] cdb_idx;
  logic [31:0]   cdb_val, cdb_tgt;
  logic          rf_en, pj, fl;
  logic [RW-1:0] rf_idx;
  logic [4:0]    rf_rd;
  logic [31:0]   rf_val, fpc;

  always #5 clk = ~clk;

  rob_commit_sequencer #(.RoB_WIDTH(RW)) dut (
    .Sys_clk(clk), .Sys_rst(rst), .Sys_rdy(rdy),
    .DPRoB_en(dp_en), .DPRoB_rd(dp_rd), .DPRoB_is_branch(dp_br),
    .RoBDP_index(dp_idx), .RoBDP_full(dp_full),
    .CDBRoB_en(cdb_en), .CDBRoB_index(cdb_idx), .CDBRoB_value(cdb_val),
    .CDBRoB_mispredict(cdb_misp), .CDBRoB_target(cdb_tgt),
    .RoBRF_en(rf_en), .RoBRF_RoB_index(rf_idx), .RoBRF_rd(rf_rd),
    .RoBRF_value(rf_val), .RoBRF_pre_judge(pj),
    .RoBAll_flush(fl), .RoBAll_flush_pc(fpc)
  );

  typedef struct {
    logic [5:0]  rd;
    bit          br;
    bit          rdy;
    logic [31:0] val;
    bit          misp;
    logic [31:0] tgt;
  } ment_t;

  ment_t       q[$];
  int          hidx;
  bit          e_en, e_pj, e_fl;
  int          e_idx;
  logic [4:0]  e_rd;
  logic [31:0] e_val, e_fpc;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs();
    chk("rf_en", 32'(rf_en), 32'(e_en));
    chk("pre_judge", 32'(pj), 32'(e_pj));
    chk("flush", 32'(fl), 32'(e_fl));
    if (e_en) begin
      chk("rf_index", 32'(rf_idx), 32'(e_idx));
      chk("rf_rd", 32'(rf_rd), 32'(e_rd));
      chk("rf_value", rf_val, e_val);
    end
    if (e_fl) chk("flush_pc", fpc, e_fpc);
  endtask

  task automatic do_reset();
    rst = 1'b1; rdy = 1'b1; dp_en = 1'b0; cdb_en = 1'b0;
    dp_rd = '0; dp_br = 1'b0; cdb_idx = '0; cdb_val = '0; cdb_misp = 1'b0; cdb_tgt = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete(); hidx = 0;
    e_en = 1'b0; e_pj = 1'b1; e_fl = 1'b0;
    chk_outputs();
    chk("rst_dp_index", 32'(dp_idx), 32'd0);
    chk("rst_dp_full", 32'(dp_full), 32'd0);
  endtask

  // One clock: drive inputs, check combinational outputs, advance the model, check registered outputs.
  task automatic cyc(input bit de, input logic [5:0] drd, input bit dbr,
                     input bit ce, input logic [RW-1:0] ci, input logic [31:0] cv,
                     input bit cm, input logic [31:0] ct, input bit r);
    bit    full, commit, misp, old_fl;
    ment_t h, n;
    rdy = r; dp_en = de; dp_rd = drd; dp_br = dbr;
    cdb_en = ce; cdb_idx = ci; cdb_val = cv; cdb_misp = cm; cdb_tgt = ct;
    chk("dp_index", 32'(dp_idx), 32'((hidx + q.size()) % DEPTH));
    chk("dp_full", 32'(dp_full), 32'(q.size() == DEPTH || e_fl));
    if (r) begin
      old_fl = e_fl;
      full   = (q.size() == DEPTH) || old_fl;
      commit = (q.size() > 0) && q[0].rdy;
      misp   = 1'b0;
      if (commit) begin
        h     = q[0];
        misp  = h.br && h.misp;
        e_idx = hidx; e_rd = h.rd[4:0]; e_val = h.val;
        e_en  = !misp && !h.br && h.rd != NREG && h.rd[4:0] != 5'd0;
        if (misp) e_fpc = h.tgt;
      end else begin
        e_en = 1'b0;
      end
      e_pj = !misp;
      e_fl = misp;
      if (ce && !old_fl)
        for (int i = 0; i < q.size(); i++)
          if ((hidx + i) % DEPTH == int'(ci)) begin
            q[i].rdy = 1'b1; q[i].val = cv; q[i].misp = cm; q[i].tgt = ct;
          end
      if (misp) begin
        q.delete(); hidx = 0;
      end else begin
        if (commit) begin
          void'(q.pop_front());
          hidx = (hidx + 1) % DEPTH;
        end
        if (de && !full) begin
          n.rd = drd; n.br = dbr; n.rdy = 1'b0; n.val = '0; n.misp = 1'b0; n.tgt = '0;
          q.push_back(n);
        end
      end
    end
    @(posedge clk); #1;
    chk_outputs();
  endtask

  task automatic idle();
    cyc(0, 6'd0, 0, 0, '0, 32'd0, 0, 32'd0, 1);
  endtask
  task automatic disp(input logic [5:0] rd, input bit br);
    cyc(1, rd, br, 0, '0, 32'd0, 0, 32'd0, 1);
  endtask
  task automatic wbk(input logic [RW-1:0] idx, input logic [31:0] v, input bit m, input logic [31:0] t);
    cyc(0, 6'd0, 0, 1, idx, v, m, t, 1);
  endtask

  initial begin
    // Reset state, including data outputs
    do_reset();
    chk("rst_rf_value", rf_val, 32'd0);
    chk("rst_flush_pc", fpc, 32'd0);
    chk("rst_rf_rd", 32'(rf_rd), 32'd0);

    // Single entry: writeback at edge N, commit visible after edge N+1, for one cycle
    disp(6'd5, 0);
    wbk(2'd0, 32'h1234, 0, 32'd0);
    chk("lat_not_yet", 32'(rf_en), 32'd0);
    idle();
    chk("lat_en", 32'(rf_en), 32'd1);
    chk("lat_rd", 32'(rf_rd), 32'd5);
    chk("lat_value", rf_val, 32'h1234);
    chk("lat_index", 32'(rf_idx), 32'd0);
    idle();
    chk("lat_one_cycle", 32'(rf_en), 32'd0);

    // Out-of-order writeback, in-order commit
    do_reset();
    disp(6'd1, 0); disp(6'd2, 0);
    wbk(2'd1, 32'hBBBB, 0, 32'd0);
    wbk(2'd0, 32'hAAAA, 0, 32'd0);
    idle();
    chk("ooo_first", 32'(rf_idx), 32'd0);
    idle();
    chk("ooo_second", 32'(rf_idx), 32'd1);
    chk("ooo_second_en", 32'(rf_en), 32'd1);
    idle();

    // Full, ignored fifth dispatch, release after retire, wrap
    do_reset();
    disp(6'd3, 0); disp(6'd4, 0); disp(6'd5, 0); disp(6'd6, 0);
    chk("full_set", 32'(dp_full), 32'd1);
    disp(6'd7, 0);
    chk("full_tail_held", 32'(dp_idx), 32'd0);
    wbk(2'd0, 32'h11, 0, 32'd0);
    idle();
    chk("full_released", 32'(dp_full), 32'd0);
    disp(6'd8, 0);
    chk("wrap_index", 32'(dp_idx), 32'd1);
    wbk(2'd1, 32'h22, 0, 32'd0); wbk(2'd2, 32'h33, 0, 32'd0);
    wbk(2'd3, 32'h44, 0, 32'd0); wbk(2'd0, 32'h55, 0, 32'd0);
    idle(); idle();

    // Mispredicted branch at idx1 with younger entries already complete
    do_reset();
    disp(6'd1, 0); disp(NREG, 1); disp(6'd2, 0); disp(6'd3, 0);
    wbk(2'd2, 32'h2, 0, 32'd0); wbk(2'd3, 32'h3, 0, 32'd0);
    wbk(2'd1, 32'h0, 1, 32'h80); wbk(2'd0, 32'h9, 0, 32'd0);
    idle();
    idle();
    chk("misp_flush", 32'(fl), 32'd1);
    chk("misp_pre_judge", 32'(pj), 32'd0);
    chk("misp_pc", fpc, 32'h80);
    chk("misp_rf_en", 32'(rf_en), 32'd0);
    cyc(1, 6'd9, 0, 1, 2'd2, 32'h5, 0, 32'd0, 1);
    chk("post_flush_index", 32'(dp_idx), 32'd0);
    chk("post_flush_no_commit", 32'(rf_en), 32'd0);
    idle(); idle();

    // Silent retires, then a three-cycle stall with a commit pending
    do_reset();
    disp(NREG, 0); disp(6'd0, 0);
    wbk(2'd0, 32'h1, 0, 32'd0); wbk(2'd1, 32'h2, 0, 32'd0);
    idle();
    chk("silent_nonreg", 32'(rf_en), 32'd0);
    idle();
    chk("silent_x0", 32'(rf_en), 32'd0);
    disp(6'd4, 0); disp(6'd5, 0);
    wbk(2'd2, 32'h44, 0, 32'd0);
    for (int s = 0; s < 3; s++) cyc(1, 6'd6, 0, 1, 2'd3, 32'h99, 0, 32'd0, 0);
    chk("stall_index", 32'(dp_idx), 32'd0);
    idle();
    chk("stall_commit_once", 32'(rf_idx), 32'd2);
    wbk(2'd3, 32'h55, 0, 32'd0);
    idle(); idle();

    // Randomized traffic with a reset in the middle
    do_reset();
    for (int n = 0; n < 600; n++) begin
      bit            de, dbr, ce, cm, r;
      logic [5:0]    drd;
      logic [RW-1:0] ci;
      int            k;
      if (n == 300) do_reset();
      de  = $urandom_range(0, 99) < 60;
      dbr = $urandom_range(0, 5) == 0;
      case ($urandom_range(0, 5))
        0:       drd = NREG;
        1:       drd = 6'd0;
        default: drd = 6'($urandom_range(1, 31));
      endcase
      if (dbr) drd = NREG;
      ce = 1'b0; cm = 1'b0; ci = RW'($urandom);
      if ($urandom_range(0, 99) < 55) begin
        ce = 1'b1;
        if (q.size() > 0 && $urandom_range(0, 9) != 0) begin
          k  = $urandom_range(0, q.size() - 1);
          ci = RW'((hidx + k) % DEPTH);
          cm = q[k].br && ($urandom_range(0, 2) == 0);
        end
      end
      r = $urandom_range(0, 9) != 0;
      cyc(de, drd, dbr, ce, ci, $urandom, cm, $urandom, r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
